// File: rtl/column_weight_pkg.sv
// column_weight_pkg
// Types and constants used by column_weight_stream and weight_row_mem.
//   state_t  : streaming FSM state (ST_IDLE, ST_RUN)
//   Q16_ONE  : 1.0 in Q16.16, the default power-up value of every stored weight
package column_weight_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [31:0] Q16_ONE = 32'h00010000;

endpackage

// File: rtl/weight_row_mem.sv
// weight_row_mem
// S rows x N lanes x n-bit weight storage with a single-lane write port and a
// combinational full-row read port. A write that targets a lane of the row
// being read in the same cycle is forwarded to the read data (write-first).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (all words -> INIT_VAL)
//   wr_en           lane write strobe
//   wr_row/wr_lane  write address; lanes >= N are dropped
//   wr_data         word to write
//   rd_row          row to read
//   rd_data         N*n row contents, lane 0 in bits [n-1:0]
module weight_row_mem
  import column_weight_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 8,
  parameter int n = 32,
  parameter logic [n-1:0] INIT_VAL = n'(Q16_ONE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(S)-1:0]          wr_row,
  input  logic [((N>1)?$clog2(N):1)-1:0] wr_lane,
  input  logic [n-1:0]                  wr_data,
  input  logic [$clog2(S)-1:0]          rd_row,
  output logic [N*n-1:0]                rd_data
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  logic [n-1:0] mem_reg [S][N];
  logic         lane_ok;

  // When N fills the lane address space every lane index is legal; otherwise
  // out-of-range lanes must be discarded both for storage and forwarding.
  generate
    if (N == (1 << LW)) begin : g_lane_full
      assign lane_ok = 1'b1;
    end else begin : g_lane_part
      assign lane_ok = (32'(wr_lane) < N);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < S; r++) begin
        for (int l = 0; l < N; l++) begin
          mem_reg[r][l] <= INIT_VAL;
        end
      end
    end else if (wr_en && lane_ok) begin
      mem_reg[wr_row][wr_lane] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rd_lane
      logic hit;
      assign hit = wr_en && lane_ok && (wr_row == rd_row) && (wr_lane == LW'(gi));
      assign rd_data[gi*n +: n] = hit ? wr_data : mem_reg[rd_row][gi];
    end
  endgenerate

endmodule

// File: rtl/column_weight_stream.sv
// column_weight_stream
// Streams the rows of an S x N weight array to a consumer over a valid/ready
// handshake, one row per cycle at full throughput, either once or wrapping
// continuously. Weights can be rewritten one lane per cycle at any time.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, loop      begin a stream (IDLE only); loop=1 wraps row S-1 -> 0
//   stop             abort a running stream (wins over start and handshake)
//   wr_en, wr_row, wr_lane, wr_data   lane write port into the weight store
//   w_valid, w_ready row handshake
//   w_data, w_row, w_last  registered row contents, row index, last-row flag
//   busy             high while streaming
module column_weight_stream
  import column_weight_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 8,
  parameter int n = 32,
  parameter logic [n-1:0] INIT_VAL = n'(Q16_ONE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          loop,
  input  logic                          stop,
  input  logic                          wr_en,
  input  logic [$clog2(S)-1:0]          wr_row,
  input  logic [((N>1)?$clog2(N):1)-1:0] wr_lane,
  input  logic [n-1:0]                  wr_data,
  output logic                          w_valid,
  input  logic                          w_ready,
  output logic [N*n-1:0]                w_data,
  output logic [$clog2(S)-1:0]          w_row,
  output logic                          w_last,
  output logic                          busy
);

  localparam int RW = $clog2(S);

  state_t           state_reg;
  logic             loop_reg;
  logic             valid_reg;
  logic             last_reg;
  logic [RW-1:0]    row_reg;
  logic [N*n-1:0]   data_reg;

  logic [RW-1:0]    row_next;
  logic [RW-1:0]    rd_row;
  logic [N*n-1:0]   rd_data;
  logic             handshake;

  // S is a power of two, so the increment wraps S-1 -> 0 on its own,
  // which is exactly the continuous-mode successor.
  assign row_next  = row_reg + RW'(1);
  assign handshake = valid_reg && w_ready;

  // The store is always addressed with the row that would be loaded on the
  // coming edge: row 0 when starting from IDLE, the successor while running.
  assign rd_row = (state_reg == ST_IDLE) ? '0 : row_next;

  weight_row_mem #(
    .N        (N),
    .S        (S),
    .n        (n),
    .INIT_VAL (INIT_VAL)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_lane (wr_lane),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      loop_reg  <= 1'b0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      row_reg   <= '0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !stop) begin
            state_reg <= ST_RUN;
            loop_reg  <= loop;
            valid_reg <= 1'b1;
            row_reg   <= '0;
            last_reg  <= 1'b0;
            data_reg  <= rd_data;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
          end else if (handshake) begin
            if ((row_reg == RW'(S-1)) && !loop_reg) begin
              state_reg <= ST_IDLE;
              valid_reg <= 1'b0;
            end else begin
              row_reg   <= row_next;
              last_reg  <= (row_next == RW'(S-1));
              data_reg  <= rd_data;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign w_valid = valid_reg;
  assign w_data  = data_reg;
  assign w_row   = row_reg;
  assign w_last  = last_reg;
  assign busy    = (state_reg == ST_RUN);

endmodule
